// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC generator for the Forth core. Decodes the
//               control-flow op of the current instruction and produces nPC,
//               which the PC register loads every cycle. Owns the hardware
//               return stack used by CALL/RET. A stack overflow or underflow
//               moves the block into a sticky FAULT state that only reset
//               clears.
// Ports       : clk_i          rising-edge clock
//               rst_ni         asynchronous active-low reset
//               pc_i           current PC (PC register output)
//               op_i           0 NEXT, 1 JMP, 2 BRZ, 3 CALL, 4 RET, 5 HALT,
//                              6/7 behave as NEXT
//               target_i       jump/branch/call destination
//               cond_i         1 = data-stack TOS is zero (BRZ taken)
//               stall_i        1 = hold PC, op ignored
//               npc_o          next PC (combinational)
//               rs_top_o       return-stack top entry, 0 when empty
//               rs_depth_o     number of valid return-stack entries
//               fault_o        1 while in FAULT
//               fault_cause_o  0 = overflow, 1 = underflow (valid with fault)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 16,
    parameter logic [WIDTH-1:0] FAULT_VEC = WIDTH'(2)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [WIDTH-1:0]           pc_i,
    input  logic [2:0]                 op_i,
    input  logic [WIDTH-1:0]           target_i,
    input  logic                       cond_i,
    input  logic                       stall_i,
    output logic [WIDTH-1:0]           npc_o,
    output logic [WIDTH-1:0]           rs_top_o,
    output logic [$clog2(DEPTH+1)-1:0] rs_depth_o,
    output logic                       fault_o,
    output logic                       fault_cause_o
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BRZ  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t           state_q;
    logic [DW-1:0]    depth_q;
    logic             cause_q;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_npc;
    logic [WIDTH-1:0] w_top;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_push_idx;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf;
    logic             w_unf;
    logic             w_full;
    logic             w_empty;

    assign w_inc      = pc_i + WIDTH'(1);
    assign w_full     = (depth_q == DW'(DEPTH));
    assign w_empty    = (depth_q == '0);
    // The top entry lives at depth-1; the next free slot is at depth.
    assign w_top_idx  = AW'(depth_q - DW'(1));
    assign w_push_idx = AW'(depth_q);
    assign w_top      = w_empty ? '0 : stack_q[w_top_idx];

    // Op decode. Outside RUN, or while stalled, the PC simply holds.
    always_comb begin
        w_npc  = pc_i;
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        if ((state_q == S_RUN) && !stall_i) begin
            case (op_i)
                OP_JMP:  w_npc = target_i;
                OP_BRZ:  w_npc = cond_i ? target_i : w_inc;
                OP_CALL: begin
                    if (w_full) begin
                        w_ovf = 1'b1;
                        w_npc = FAULT_VEC;
                    end else begin
                        w_push = 1'b1;
                        w_npc  = target_i;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_unf = 1'b1;
                        w_npc = FAULT_VEC;
                    end else begin
                        w_pop = 1'b1;
                        w_npc = w_top;
                    end
                end
                OP_HALT: w_npc = pc_i;
                default: w_npc = w_inc;
            endcase
        end
    end

    // State, stack and fault cause. The stack is frozen once FAULT is entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RUN;
            depth_q <= '0;
            cause_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (w_push) begin
                        stack_q[w_push_idx] <= w_inc;
                        depth_q             <= depth_q + DW'(1);
                    end else if (w_pop) begin
                        depth_q <= depth_q - DW'(1);
                    end
                    if (w_ovf || w_unf) begin
                        state_q <= S_FAULT;
                        cause_q <= w_unf;
                    end
                end
                default: state_q <= S_FAULT;
            endcase
        end
    end

    assign npc_o         = w_npc;
    assign rs_top_o      = w_top;
    assign rs_depth_o    = depth_q;
    assign fault_o       = (state_q == S_FAULT);
    assign fault_cause_o = cause_q;

endmodule
`default_nettype wire
